// File: rtl/axil_seq_pkg.sv
// Shared types and constants for the AXI-lite command sequencer.
// Widths are fixed here so the command payload struct is one packed type.
package axil_seq_pkg;

    localparam int unsigned AXI_WIDTH      = 64;
    localparam int unsigned AXI_ADDR_WIDTH = 6;
    localparam int unsigned AXI_RESP_WIDTH = 3;

    localparam logic [AXI_RESP_WIDTH-1:0] RESP_SLVERR = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

    typedef struct packed {
        logic                      we;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [AXI_WIDTH-1:0]      wdata;
    } cmd_t;

endpackage

// File: rtl/axil_seq_fifo.sv
// Synchronous command FIFO; pointers carry an extra MSB so full and empty are distinguishable.
module axil_seq_fifo
    import axil_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_cmd,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W:0] ptr_t;

    cmd_t mem_q [DEPTH];
    cmd_t mem_d [DEPTH];
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;

    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Push is refused when full, regardless of a same-cycle pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_cmd;
            wr_ptr_d                   = wr_ptr_q + ptr_t'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/axil_cmd_sequencer.sv
// Buffers commands and issues them one at a time to the AXI-lite master, returning one response each.
// Define AXIL_SEQ_TIMEOUT_EN to force an SLVERR completion after TIMEOUT_CYCLES without a bus response.
module axil_cmd_sequencer
    import axil_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
`ifdef AXIL_SEQ_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXI_WIDTH-1:0]      cmd_wdata,
    output logic                      writeEn,
    output logic                      readEn,
    output logic [AXI_ADDR_WIDTH-1:0] wr_addr,
    output logic [AXI_ADDR_WIDTH-1:0] rd_addr,
    output logic [AXI_WIDTH-1:0]      data,
    input  logic                      bus_bvalid,
    input  logic [AXI_RESP_WIDTH-1:0] bus_bresp,
    input  logic                      bus_rvalid,
    input  logic [AXI_RESP_WIDTH-1:0] bus_rresp,
    input  logic [AXI_WIDTH-1:0]      bus_rdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_is_read,
    output logic [AXI_WIDTH-1:0]      rsp_data,
    output logic [AXI_RESP_WIDTH-1:0] rsp_resp
);

    state_t                    state_q, state_d;
    logic                      write_en_q, write_en_d;
    logic                      read_en_q, read_en_d;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [AXI_WIDTH-1:0]      data_q, data_d;
    logic                      bvalid_q, rvalid_q;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_is_read_q, rsp_is_read_d;
    logic [AXI_WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic [AXI_RESP_WIDTH-1:0] rsp_resp_q, rsp_resp_d;

    cmd_t head;
    logic fifo_full, fifo_empty;
    logic pop_c, b_rise_c, r_rise_c, timeout_c;

    axil_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cmd_valid),
        .push_cmd ('{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata}),
        .pop      (pop_c),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign pop_c     = (state_q == IDLE) && !fifo_empty;
    // Only a fresh edge completes; a level left over from a prior command does not.
    assign b_rise_c  = bus_bvalid && !bvalid_q;
    assign r_rise_c  = bus_rvalid && !rvalid_q;

`ifdef AXIL_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_c;

    assign busy_c    = (state_q == WR) || (state_q == RD);
    assign timeout_c = busy_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (pop_c) begin
            cnt_d = '0;
        end else if (busy_c && !timeout_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and registered-output logic; a real bus edge takes priority over a timeout.
    always_comb begin
        state_d       = state_q;
        write_en_d    = write_en_q;
        read_en_d     = read_en_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        data_d        = data_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_is_read_d = rsp_is_read_q;
        rsp_data_d    = rsp_data_q;
        rsp_resp_d    = rsp_resp_q;
        case (state_q)
            IDLE: begin
                if (pop_c) begin
                    if (head.we) begin
                        state_d    = WR;
                        write_en_d = 1'b1;
                        wr_addr_d  = head.addr;
                        data_d     = head.wdata;
                    end else begin
                        state_d   = RD;
                        read_en_d = 1'b1;
                        rd_addr_d = head.addr;
                    end
                end
            end
            WR: begin
                if (b_rise_c || timeout_c) begin
                    state_d       = RSP;
                    write_en_d    = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_is_read_d = 1'b0;
                    rsp_data_d    = '0;
                    rsp_resp_d    = b_rise_c ? bus_bresp : RESP_SLVERR;
                end
            end
            RD: begin
                if (r_rise_c || timeout_c) begin
                    state_d       = RSP;
                    read_en_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_is_read_d = 1'b1;
                    rsp_data_d    = r_rise_c ? bus_rdata : '0;
                    rsp_resp_d    = r_rise_c ? bus_rresp : RESP_SLVERR;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            write_en_q    <= 1'b0;
            read_en_q     <= 1'b0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            data_q        <= '0;
            bvalid_q      <= 1'b0;
            rvalid_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_is_read_q <= 1'b0;
            rsp_data_q    <= '0;
            rsp_resp_q    <= '0;
        end else begin
            state_q       <= state_d;
            write_en_q    <= write_en_d;
            read_en_q     <= read_en_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            data_q        <= data_d;
            bvalid_q      <= bus_bvalid;
            rvalid_q      <= bus_rvalid;
            rsp_valid_q   <= rsp_valid_d;
            rsp_is_read_q <= rsp_is_read_d;
            rsp_data_q    <= rsp_data_d;
            rsp_resp_q    <= rsp_resp_d;
        end
    end

    assign writeEn     = write_en_q;
    assign readEn      = read_en_q;
    assign wr_addr     = wr_addr_q;
    assign rd_addr     = rd_addr_q;
    assign data        = data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_is_read = rsp_is_read_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_resp    = rsp_resp_q;

endmodule

// File: tb/tb_axil_cmd_sequencer.sv
// Self-checking bench for axil_cmd_sequencer: directed scenarios plus a randomized run against a queue model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axil_cmd_sequencer;

    localparam int unsigned W  = 64;
    localparam int unsigned AW = 6;
    localparam int unsigned RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [W-1:0]  cmd_wdata;
    logic          writeEn, readEn;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [W-1:0]  data;
    logic          bus_bvalid, bus_rvalid;
    logic [RW-1:0] bus_bresp, bus_rresp;
    logic [W-1:0]  bus_rdata;
    logic          rsp_valid, rsp_ready, rsp_is_read;
    logic [W-1:0]  rsp_data;
    logic [RW-1:0] rsp_resp;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
    } tcmd_t;

    typedef struct {
        bit            is_read;
        logic [W-1:0]  rdata;
        logic [RW-1:0] resp;
    } trsp_t;

    always #5 clk = ~clk;

    axil_cmd_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .writeEn     (writeEn),
        .readEn      (readEn),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .data        (data),
        .bus_bvalid  (bus_bvalid),
        .bus_bresp   (bus_bresp),
        .bus_rvalid  (bus_rvalid),
        .bus_rresp   (bus_rresp),
        .bus_rdata   (bus_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_is_read (rsp_is_read),
        .rsp_data    (rsp_data),
        .rsp_resp    (rsp_resp)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        bus_bvalid = 1'b0;
        bus_bresp  = '0;
        bus_rvalid = 1'b0;
        bus_rresp  = '0;
        bus_rdata  = '0;
        rsp_ready  = 1'b0;
    endtask

    // which: 0 writeEn, 1 readEn, 2 rsp_valid, 3 either enable
    task automatic wait_sig(input int which, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if ((which == 0 && writeEn) || (which == 1 && readEn) ||
                (which == 2 && rsp_valid) || (which == 3 && (writeEn || readEn))) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Offer one command and hold it until the sequencer takes it (bounded).
    task automatic push_cmd(input bit we, input logic [AW-1:0] addr, input logic [W-1:0] wd, output bit ok);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wd;
        ok        = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_checks++; if (writeEn !== 1'b0)   begin n_fail++; $display("FAIL reset_writeEn got %0b want 0", writeEn); end
        n_checks++; if (readEn !== 1'b0)    begin n_fail++; $display("FAIL reset_readEn got %0b want 0", readEn); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); end
        n_checks++; if (rsp_data !== '0 || rsp_resp !== '0 || wr_addr !== '0 || data !== '0)
            begin n_fail++; $display("FAIL reset_buses got rsp_data=%h rsp_resp=%0d wr_addr=%0d data=%h want all 0", rsp_data, rsp_resp, wr_addr, data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 6'h05; cmd_wdata = 64'hA5;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_ready got %0b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (writeEn !== 1'b0) begin n_fail++; $display("FAIL wr_latency_early got writeEn=%0b want 0", writeEn); end
        tick();
        n_checks++; if (writeEn !== 1'b1 || readEn !== 1'b0) begin n_fail++; $display("FAIL wr_enable got writeEn=%0b readEn=%0b want 1/0", writeEn, readEn); end
        n_checks++; if (wr_addr !== 6'h05 || data !== 64'hA5) begin n_fail++; $display("FAIL wr_payload got addr=%h data=%h want 05/a5", wr_addr, data); end
        // A read-channel edge must not complete a write.
        bus_rvalid = 1'b1; bus_rresp = 3'b111;
        tick();
        bus_rvalid = 1'b0;
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || writeEn !== 1'b1) begin n_fail++; $display("FAIL wr_cross_channel got rsp_valid=%0b writeEn=%0b want 0/1", rsp_valid, writeEn); end
        bus_bvalid = 1'b1; bus_bresp = 3'b001;
        tick();
        bus_bvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || writeEn !== 1'b0) begin n_fail++; $display("FAIL wr_complete got rsp_valid=%0b writeEn=%0b want 1/0", rsp_valid, writeEn); end
        n_checks++; if (rsp_is_read !== 1'b0 || rsp_data !== '0 || rsp_resp !== 3'b001)
            begin n_fail++; $display("FAIL wr_rsp got is_read=%0b data=%h resp=%0d want 0/0/1", rsp_is_read, rsp_data, rsp_resp); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_consume got rsp_valid=%0b want 0", rsp_valid); end
    endtask

    task automatic test_read();
        bit ok;
        push_cmd(1'b0, 6'h05, 64'h0, ok);
        wait_sig(1, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_enable_timeout got readEn=0 want 1 within 20 cycles"); end
        n_checks++; if (readEn !== 1'b1 || writeEn !== 1'b0 || rd_addr !== 6'h05)
            begin n_fail++; $display("FAIL rd_enable got readEn=%0b writeEn=%0b rd_addr=%h want 1/0/05", readEn, writeEn, rd_addr); end
        bus_rvalid = 1'b1; bus_rresp = 3'b001; bus_rdata = 64'hA5;
        tick();
        bus_rvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_is_read !== 1'b1 || rsp_data !== 64'hA5 || rsp_resp !== 3'b001)
            begin n_fail++; $display("FAIL rd_rsp got valid=%0b is_read=%0b data=%h resp=%0d want 1/1/a5/1", rsp_valid, rsp_is_read, rsp_data, rsp_resp); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        tcmd_t model[$];
        tcmd_t c;
        bit    ok;
        for (int i = 0; i < 5; i++) begin
            c.we = 1'($urandom); c.addr = AW'($urandom); c.wdata = {$urandom, $urandom};
            cmd_valid = 1'b1; cmd_we = c.we; cmd_addr = c.addr; cmd_wdata = c.wdata;
            n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d got %0b want 1", i, cmd_ready); end
            model.push_back(c);
            tick();
        end
        // Sixth offer must be refused while full.
        cmd_we = 1'b1; cmd_addr = 6'h3F; cmd_wdata = '1;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full got cmd_ready=%0b want 0", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            trsp_t e;
            wait_sig(3, 50, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_issue_timeout_%0d got no enable want enable within 50 cycles", k); end
            c = model[k];
            n_checks++; if (writeEn !== c.we || readEn !== !c.we || (c.we ? wr_addr : rd_addr) !== c.addr || (c.we && data !== c.wdata))
                begin n_fail++; $display("FAIL b2b_order_%0d got wr=%0b rd=%0b wa=%h ra=%h d=%h want we=%0b a=%h d=%h",
                                        k, writeEn, readEn, wr_addr, rd_addr, data, c.we, c.addr, c.wdata); end
            e.is_read = !c.we; e.resp = RW'($urandom); e.rdata = c.we ? '0 : {$urandom, $urandom};
            if (c.we) begin bus_bvalid = 1'b1; bus_bresp = e.resp; end
            else      begin bus_rvalid = 1'b1; bus_rresp = e.resp; bus_rdata = e.rdata; end
            tick();
            bus_bvalid = 1'b0; bus_rvalid = 1'b0;
            n_checks++; if (rsp_valid !== 1'b1 || rsp_is_read !== e.is_read || rsp_data !== e.rdata || rsp_resp !== e.resp)
                begin n_fail++; $display("FAIL b2b_rsp_%0d got v=%0b r=%0b d=%h resp=%0d want 1/%0b/%h/%0d",
                                        k, rsp_valid, rsp_is_read, rsp_data, rsp_resp, e.is_read, e.rdata, e.resp); end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_bvalid_held();
        bit ok;
        push_cmd(1'b1, 6'h11, 64'h1111, ok);
        wait_sig(0, 20, ok);
        bus_bvalid = 1'b1; bus_bresp = 3'b010;
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 3'b010) begin n_fail++; $display("FAIL held_first got v=%0b resp=%0d want 1/2", rsp_valid, rsp_resp); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        push_cmd(1'b1, 6'h22, 64'h2222, ok);
        wait_sig(0, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL held_issue_timeout got writeEn=0 want 1"); end
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (rsp_valid !== 1'b0 || writeEn !== 1'b1) begin n_fail++; $display("FAIL held_level_ignored got v=%0b writeEn=%0b want 0/1", rsp_valid, writeEn); end
        bus_bvalid = 1'b0;
        tick();
        bus_bvalid = 1'b1; bus_bresp = 3'b000;
        tick();
        bus_bvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 3'b000 || writeEn !== 1'b0)
            begin n_fail++; $display("FAIL held_second got v=%0b resp=%0d writeEn=%0b want 1/0/0", rsp_valid, rsp_resp, writeEn); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_rsp_stall();
        bit           ok, stable;
        logic [W-1:0] rd;
        push_cmd(1'b0, 6'h2A, 64'h0, ok);
        push_cmd(1'b1, 6'h15, 64'hDEAD_BEEF, ok);
        wait_sig(1, 20, ok);
        rd = {$urandom, $urandom};
        bus_rvalid = 1'b1; bus_rresp = 3'b011; bus_rdata = rd;
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = ~rd;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_is_read !== 1'b1 || rsp_data !== rd || rsp_resp !== 3'b011 ||
                writeEn !== 1'b0 || readEn !== 1'b0) stable = 1'b0;
            tick();
        end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL stall_hold got d=%h resp=%0d wr=%0b rd=%0b want %h/3/0/0", rsp_data, rsp_resp, writeEn, readEn, rd); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        wait_sig(0, 10, ok);
        n_checks++; if (!ok || wr_addr !== 6'h15 || data !== 64'hDEAD_BEEF)
            begin n_fail++; $display("FAIL stall_next got ok=%0b addr=%h data=%h want 1/15/deadbeef", ok, wr_addr, data); end
        bus_bvalid = 1'b1; bus_bresp = 3'b000;
        tick();
        bus_bvalid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        localparam int N = 40;
        tcmd_t pend[$];
        tcmd_t c;
        trsp_t exp_rsp;
        int    pushed = 0, done = 0, delay = 0, cyc = 0;
        bit    issued = 1'b0, pulsed = 1'b0, checked = 1'b0;
        while (done < N && cyc < 5000) begin
            cyc++;
            bus_bvalid = 1'b0;
            bus_rvalid = 1'b0;
            if (writeEn && readEn) begin
                n_checks++; n_fail++; $display("FAIL rand_both_enables got wr=1 rd=1 want at most one");
            end
            if (rsp_valid) begin
                if (!checked) begin
                    n_checks++;
                    if (!pulsed || rsp_is_read !== exp_rsp.is_read || rsp_data !== exp_rsp.rdata || rsp_resp !== exp_rsp.resp)
                        begin n_fail++; $display("FAIL rand_rsp_%0d got r=%0b d=%h resp=%0d want %0b/%h/%0d",
                                                done, rsp_is_read, rsp_data, rsp_resp, exp_rsp.is_read, exp_rsp.rdata, exp_rsp.resp); end
                    checked = 1'b1;
                end
                rsp_ready = 1'($urandom);
                if (rsp_ready) begin
                    done++; issued = 1'b0; pulsed = 1'b0; checked = 1'b0;
                end
            end else begin
                rsp_ready = 1'($urandom);
            end
            if (!issued && (writeEn || readEn)) begin
                n_checks++;
                if (pend.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious_issue got enable with empty model want none");
                end else begin
                    c = pend.pop_front();
                    if (writeEn !== c.we || (c.we ? wr_addr : rd_addr) !== c.addr || (c.we && data !== c.wdata))
                        begin n_fail++; $display("FAIL rand_issue_%0d got wr=%0b wa=%h ra=%h d=%h want we=%0b a=%h d=%h",
                                                done, writeEn, wr_addr, rd_addr, data, c.we, c.addr, c.wdata); end
                end
                issued = 1'b1;
                delay  = $urandom_range(0, 6);
            end
            if (issued && !pulsed) begin
                if (delay == 0) begin
                    exp_rsp.is_read = !c.we;
                    exp_rsp.resp    = RW'($urandom);
                    exp_rsp.rdata   = c.we ? '0 : {$urandom, $urandom};
                    if (c.we) begin bus_bvalid = 1'b1; bus_bresp = exp_rsp.resp; end
                    else      begin bus_rvalid = 1'b1; bus_rresp = exp_rsp.resp; bus_rdata = exp_rsp.rdata; end
                    pulsed = 1'b1;
                end else begin
                    delay--;
                end
            end
            if (pushed < N) begin
                cmd_valid = 1'($urandom);
                cmd_we    = 1'($urandom);
                cmd_addr  = AW'($urandom);
                cmd_wdata = {$urandom, $urandom};
                if (cmd_valid && cmd_ready) begin
                    pend.push_back('{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata});
                    pushed++;
                end
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        idle_inputs();
        n_checks++; if (done != N) begin n_fail++; $display("FAIL rand_completion got %0d responses want %0d", done, N); end
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int hi = 0;
        push_cmd(1'b1, 6'h07, 64'h77, ok);
        wait_sig(0, 20, ok);
`ifdef AXIL_SEQ_TIMEOUT_EN
        for (int i = 0; i < 200 && !rsp_valid; i++) begin
            if (writeEn) hi++;
            tick();
        end
        n_checks++; if (hi != 64) begin n_fail++; $display("FAIL timeout_cycles got %0d want 64", hi); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 3'b010 || rsp_data !== '0 || rsp_is_read !== 1'b0)
            begin n_fail++; $display("FAIL timeout_rsp got v=%0b resp=%0d d=%h r=%0b want 1/2/0/0", rsp_valid, rsp_resp, rsp_data, rsp_is_read); end
`else
        for (int i = 0; i < 100; i++) begin
            if (writeEn) hi++;
            tick();
        end
        n_checks++; if (hi != 100 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL no_timeout_wait got hi=%0d v=%0b want 100/0", hi, rsp_valid); end
        bus_bvalid = 1'b1; bus_bresp = 3'b001;
        tick();
        bus_bvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 3'b001) begin n_fail++; $display("FAIL no_timeout_rsp got v=%0b resp=%0d want 1/1", rsp_valid, rsp_resp); end
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        push_cmd(1'b1, 6'h09, 64'h99, ok);
        wait_sig(0, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_issue got writeEn=0 want 1"); end
        rst = 1'b1;
        tick();
        n_checks++; if (writeEn !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            begin n_fail++; $display("FAIL rstmid_state got wr=%0b v=%0b ready=%0b want 0/0/1", writeEn, rsp_valid, cmd_ready); end
        rst = 1'b0;
        tick();
        bus_bvalid = 1'b1;
        tick();
        bus_bvalid = 1'b0;
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || writeEn !== 1'b0) begin n_fail++; $display("FAIL rstmid_dropped got v=%0b wr=%0b want 0/0", rsp_valid, writeEn); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_bvalid_held();
        test_rsp_stall();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
